seg_mem2_q: RTL and testbench

Queued second memory stage for the dual-issue core, placed between MEM1 and WB. Holds up to `DEPTH` issued bundles (primary + secondary slot), matches in-order `data_data_ok_i` responses to the oldest bundle still awaiting data, and retires bundles in order to WB. A memory response is captured even while WB is stalled, so a WB stall never drops data. Load data extraction (byte/half/word, sign/zero extend, LWL/LWR merge) and the ID stall/bypass buses come from this stage.

---
 rtl/seg_mem2_q.sv | 207 ++++++++++++++++++++
 tb/tb_seg_mem2_q.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_mem2_q.sv
// seg_mem2_q: queued MEM2 stage of the dual-issue pipe, sitting between MEM1 and WB.
// Holds up to DEPTH bundles. In-order memory responses are matched to the oldest
// bundle still waiting for data. Bundles retire in order to WB. A response is captured
// even while WB stalls. The stage also extracts load results and drives the ID
// stall/bypass buses.
// Optional feature macro: MEM2_UNALIGNED_EN enables the LWL/LWR merge with opdata2.
module seg_mem2_q #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_allowin_i,
    input  logic                 mem1_mem2_valid_i,
    input  logic [145:0]         mem1_mem2_bus_primary_i,
    input  logic [69:0]          mem1_mem2_bus_secondary_i,
    input  logic [31:0]          mem_rdata_i,
    input  logic                 data_data_ok_i,
    output logic                 mem2_allowin_o,
    output logic                 mem2_wb_valid_o,
    output logic [69:0]          mem2_wb_bus_primary_o,
    output logic [69:0]          mem2_wb_bus_secondary_o,
    output logic [6*DEPTH-1:0]   mem2_up_bus_o,
    output logic [75:0]          mem2_bypass_o,
    output logic                 mem2_resp_err_o
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [3:0] SEL_LOAD  = 4'd7;
    localparam logic [3:0] SEL_STORE = 4'd8;
    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LWL = 8'h22;
    localparam logic [7:0] OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24;
    localparam logic [7:0] OP_LHU = 8'h25;
    localparam logic [7:0] OP_LWR = 8'h26;
    localparam logic [7:0] OP_LL  = 8'h30;
    localparam logic [7:0] OP_SC  = 8'h38;

    // Entry payload (not reset) and entry status flags (reset)
    logic [145:0]     pri_q   [DEPTH];
    logic [69:0]      sec_q   [DEPTH];
    logic [31:0]      rdata_q [DEPTH];
    logic [DEPTH-1:0] valid_q, need_q, got_q;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rsp_ptr;
    logic [PTR_W:0]   count;
    logic             resp_err_q;

    logic        full, empty, push, pop, push_need;
    logic        rsp_found, rsp_hit_head, head_have_data, head_ready;
    logic [145:0] head_pri;
    logic [69:0]  head_sec;
    logic [31:0]  head_rdata, pri_result;
    logic         unused_addr_hi;

    // Little-endian load extraction; unaligned merge only when the macro is set
    function automatic logic [31:0] load_result(input logic [7:0] op, input logic [1:0] off,
                                                input logic [31:0] rd, input logic [31:0] op2);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        sh  = rd >> {off, 3'b000};
        b   = sh[7:0];
        h   = off[1] ? rd[31:16] : rd[15:0];
        res = rd;
        case (op)
            OP_LB:        res = {{24{b[7]}}, b};
            OP_LBU:       res = {24'd0, b};
            OP_LH:        res = off[0] ? 32'd0 : {{16{h[15]}}, h};
            OP_LHU:       res = off[0] ? 32'd0 : {16'd0, h};
            OP_LW, OP_LL: res = rd;
`ifdef MEM2_UNALIGNED_EN
            OP_LWL: begin
                case (off)
                    2'd0:    res = {rd[7:0],  op2[23:0]};
                    2'd1:    res = {rd[15:0], op2[15:0]};
                    2'd2:    res = {rd[23:0], op2[7:0]};
                    default: res = rd;
                endcase
            end
            OP_LWR: begin
                case (off)
                    2'd0:    res = rd;
                    2'd1:    res = {op2[31:24], rd[31:8]};
                    2'd2:    res = {op2[31:16], rd[31:16]};
                    default: res = {op2[31:8],  rd[31:24]};
                endcase
            end
`else
            OP_LWL, OP_LWR: res = op2;
`endif
            default:      res = rd;
        endcase
        return res;
    endfunction

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    assign push_need = (mem1_mem2_bus_primary_i[73:70] == SEL_LOAD)
                    || (mem1_mem2_bus_primary_i[73:70] == SEL_STORE && mem1_mem2_bus_primary_i[81:74] != OP_SC)
                    || (mem1_mem2_bus_primary_i[81:74] == OP_SC && mem1_mem2_bus_primary_i[38]);

    // Oldest registered entry still waiting for its response (lowest offset from head wins)
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rsp_found = 1'b0;
        rsp_ptr   = rd_ptr;
        for (int k = DEPTH-1; k >= 0; k--) begin
            logic [PTR_W-1:0] idx;
            idx = rd_ptr + PTR_W'(k);
            if (valid_q[idx] && need_q[idx] && !got_q[idx]) begin
                rsp_found = 1'b1;
                rsp_ptr   = idx;
            end
        end
    end

    assign head_pri       = pri_q[rd_ptr];
    assign head_sec       = sec_q[rd_ptr];
    assign rsp_hit_head   = rsp_found && (rsp_ptr == rd_ptr);
    assign head_have_data = got_q[rd_ptr] || (rsp_hit_head && data_data_ok_i);
    assign head_ready     = valid_q[rd_ptr] && (!need_q[rd_ptr] || head_have_data);
    assign head_rdata     = got_q[rd_ptr] ? rdata_q[rd_ptr] : mem_rdata_i;
    assign pri_result     = (head_pri[73:70] == SEL_LOAD)
                          ? load_result(head_pri[81:74], head_pri[83:82], head_rdata, head_pri[145:114])
                          : head_pri[69:38];
    assign unused_addr_hi = ^head_pri[113:84];

    assign pop             = head_ready && wb_allowin_i;
    assign push            = mem1_mem2_valid_i && mem2_allowin_o;
    assign mem2_allowin_o  = !full || pop;
    assign mem2_wb_valid_o = pop;
    assign mem2_resp_err_o = resp_err_q;

    // Head-entry buses toward WB and the ID bypass network, zero while empty
    always_comb begin
        mem2_wb_bus_primary_o   = '0;
        mem2_wb_bus_secondary_o = '0;
        mem2_bypass_o           = '0;
        if (!empty) begin
            mem2_wb_bus_primary_o   = {pri_result, head_pri[37:0]};
            mem2_wb_bus_secondary_o = head_sec;
            mem2_bypass_o           = {head_sec[69:32], pri_result, head_pri[37:32]};
        end
    end

    // Per-physical-entry {waddr_primary, not_fwd} for the ID stall logic
    always_comb begin
        mem2_up_bus_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                mem2_up_bus_o[6*i +: 6] = {pri_q[i][37:33],
                    (PTR_W'(i) == rd_ptr) ? (pri_q[i][73:70] == SEL_LOAD && !head_have_data)
                                          : pri_q[i][32]};
            end
        end
    end

    // Queue control: pointers, occupancy, status flags and the sticky error
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every read sees the pre-edge value.
        if (rst) begin
            valid_q    <= '0;
            need_q     <= '0;
            got_q      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            resp_err_q <= 1'b0;
        end else begin
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            if (data_data_ok_i) begin
                if (rsp_found) got_q[rsp_ptr] <= 1'b1;
                else           resp_err_q     <= 1'b1;
            end
            // Push comes last so it wins over a pop/response to the same slot when full
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                need_q[wr_ptr]  <= push_need;
                got_q[wr_ptr]   <= 1'b0;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload and captured response data
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset; the valid flags alone decide what is live.
        if (push) begin
            pri_q[wr_ptr] <= mem1_mem2_bus_primary_i;
            sec_q[wr_ptr] <= mem1_mem2_bus_secondary_i;
        end
        if (data_data_ok_i && rsp_found) begin
            rdata_q[rsp_ptr] <= mem_rdata_i;
        end
    end
endmodule

// File: tb/tb_seg_mem2_q.sv
// Directed self-checking bench for seg_mem2_q (DEPTH = 4).
module tb_seg_mem2_q;
    localparam logic [3:0] SEL_ALU   = 4'd1;
    localparam logic [3:0] SEL_LOAD  = 4'd7;
    localparam logic [3:0] SEL_STORE = 4'd8;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LWL = 8'h22;
    localparam logic [7:0] OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24;
    localparam logic [7:0] OP_LHU = 8'h25;
    localparam logic [7:0] OP_LWR = 8'h26;
    localparam logic [7:0] OP_SC  = 8'h38;

    logic         clk = 1'b0;
    logic         rst;
    logic         wb_allowin;
    logic         mem1_valid;
    logic [145:0] pri_bus;
    logic [69:0]  sec_bus;
    logic [31:0]  rdata;
    logic         data_ok;
    logic         allowin, wb_valid, resp_err;
    logic [69:0]  wb_pri, wb_sec;
    logic [23:0]  up_bus;
    logic [75:0]  bypass;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg_mem2_q #(.DEPTH(4)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .wb_allowin_i              (wb_allowin),
        .mem1_mem2_valid_i         (mem1_valid),
        .mem1_mem2_bus_primary_i   (pri_bus),
        .mem1_mem2_bus_secondary_i (sec_bus),
        .mem_rdata_i               (rdata),
        .data_data_ok_i            (data_ok),
        .mem2_allowin_o            (allowin),
        .mem2_wb_valid_o           (wb_valid),
        .mem2_wb_bus_primary_o     (wb_pri),
        .mem2_wb_bus_secondary_o   (wb_sec),
        .mem2_up_bus_o             (up_bus),
        .mem2_bypass_o             (bypass),
        .mem2_resp_err_o           (resp_err)
    );

    function automatic logic [145:0] mk_pri(input logic [31:0] op2, input logic [31:0] addr,
                                            input logic [7:0] op, input logic [3:0] sel,
                                            input logic [31:0] wdata, input logic [4:0] waddr,
                                            input logic we, input logic [31:0] pc);
        return {op2, addr, op, sel, wdata, waddr, we, pc};
    endfunction

    function automatic logic [69:0] mk_sec(input logic [31:0] wdata, input logic [4:0] waddr,
                                           input logic we, input logic [31:0] pc);
        return {wdata, waddr, we, pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        mem1_valid = 1'b0;
        data_ok    = 1'b0;
        wb_allowin = 1'b1;
        pri_bus    = '0;
        sec_bus    = '0;
        rdata      = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        step();
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if (allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin: got %b want 1", allowin); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        n_cmp++; if ({wb_pri, wb_sec} !== 140'd0) begin n_err++; $display("FAIL reset_wb_bus: got %h/%h want 0", wb_pri, wb_sec); end
        n_cmp++; if (up_bus !== 24'd0) begin n_err++; $display("FAIL reset_up_bus: got %h want 0", up_bus); end
        n_cmp++; if (bypass !== 76'd0) begin n_err++; $display("FAIL reset_bypass: got %h want 0", bypass); end
        n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        step();
    endtask

    task automatic test_lw();
        mem1_valid = 1'b1;
        pri_bus = mk_pri(32'd0, 32'h100, OP_LW, SEL_LOAD, 32'd0, 5'd5, 1'b1, 32'h1000);
        sec_bus = mk_sec(32'd0, 5'd0, 1'b0, 32'h1004);
        step();
        set_idle();
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL lw_wait_valid: got %b want 0", wb_valid); end
        n_cmp++; if (up_bus[5:0] !== 6'h0B) begin n_err++; $display("FAIL lw_up_bus: got %h want 0b", up_bus[5:0]); end
        step();
        data_ok = 1'b1;
        rdata   = 32'hDEADBEEF;
        #1;
        n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL lw_retire_valid: got %b want 1", wb_valid); end
        n_cmp++; if (wb_pri !== {32'hDEADBEEF, 5'd5, 1'b1, 32'h1000}) begin n_err++; $display("FAIL lw_wb_pri: got %h want %h", wb_pri, {32'hDEADBEEF, 5'd5, 1'b1, 32'h1000}); end
        n_cmp++; if (wb_sec !== {32'd0, 5'd0, 1'b0, 32'h1004}) begin n_err++; $display("FAIL lw_wb_sec: got %h", wb_sec); end
        step();
        set_idle();
        #1;
        n_cmp++; if ({wb_valid, wb_pri} !== 71'd0) begin n_err++; $display("FAIL lw_empty_after: got %b/%h want 0", wb_valid, wb_pri); end
        step();
    endtask

    task automatic test_sub_word();
        logic [7:0]  ops  [4];
        logic [1:0]  offs [4];
        logic [31:0] rds  [4];
        logic [31:0] exps [4];
        ops  = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
        offs = '{2'd3, 2'd3, 2'd2, 2'd0};
        rds  = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h8001_7FFF, 32'h8001_7FFF};
        exps = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF};
        for (int i = 0; i < 4; i++) begin
            mem1_valid = 1'b1;
            pri_bus = mk_pri(32'd0, {30'h80, offs[i]}, ops[i], SEL_LOAD, 32'd0, 5'd3, 1'b1, 32'h1100);
            step();
            set_idle();
            data_ok = 1'b1;
            rdata   = rds[i];
            #1;
            n_cmp++; if ({wb_valid, wb_pri[69:38]} !== {1'b1, exps[i]}) begin n_err++; $display("FAIL subword_%0d: got valid %b result %h want 1 %h", i, wb_valid, wb_pri[69:38], exps[i]); end
            step();
            set_idle();
        end
    endtask

    task automatic test_wb_stall();
        do_reset();
        wb_allowin = 1'b0;
        for (int i = 0; i < 6; i++) begin
            automatic logic exp_allow = (i < 4);
            mem1_valid = (i < 5);
            pri_bus = mk_pri(32'd0, 32'h300 + 32'(4*i), OP_LW, SEL_LOAD, 32'd0, 5'(i+1), 1'b1, 32'h2000 + 32'(8*i));
            data_ok = (i >= 1 && i <= 4);
            rdata   = 32'(i);
            #1;
            n_cmp++; if (allowin !== exp_allow) begin n_err++; $display("FAIL stall_allowin_%0d: got %b want %b", i, allowin, exp_allow); end
            n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL stall_wb_valid_%0d: got %b want 0", i, wb_valid); end
            if (i == 5) begin
                n_cmp++; if (up_bus !== {6'h09, 6'h07, 6'h05, 6'h02}) begin n_err++; $display("FAIL stall_up_bus: got %h want %h", up_bus, {6'h09, 6'h07, 6'h05, 6'h02}); end
            end
            step();
        end
        set_idle();
        for (int j = 0; j < 4; j++) begin
            #1;
            n_cmp++; if ({wb_valid, wb_pri[69:33]} !== {1'b1, 32'(j+1), 5'(j+1)}) begin n_err++; $display("FAIL stall_retire_%0d: got valid %b result %h waddr %0d want 1 %0d %0d", j, wb_valid, wb_pri[69:38], wb_pri[37:33], j+1, j+1); end
            step();
        end
        #1;
        n_cmp++; if ({wb_valid, allowin} !== 2'b01) begin n_err++; $display("FAIL stall_drained: got valid %b allowin %b want 0 1", wb_valid, allowin); end
        step();
    endtask

    task automatic test_mixed();
        do_reset();
        mem1_valid = 1'b1;
        pri_bus = mk_pri(32'd0, 32'd0, OP_ADD, SEL_ALU, 32'h111, 5'd6, 1'b1, 32'h3000);
        step();
        pri_bus = mk_pri(32'd0, 32'h400, OP_LW, SEL_LOAD, 32'd0, 5'd7, 1'b1, 32'h3008);
        #1;
        n_cmp++; if ({wb_valid, wb_pri[69:38]} !== {1'b1, 32'h111}) begin n_err++; $display("FAIL mixed_alu_a: got %b %h want 1 111", wb_valid, wb_pri[69:38]); end
        step();
        pri_bus = mk_pri(32'd0, 32'd0, OP_ADD, SEL_ALU, 32'h222, 5'd8, 1'b1, 32'h3010);
        sec_bus = mk_sec(32'h333, 5'd9, 1'b1, 32'h3014);
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL mixed_load_wait_c2: got %b want 0", wb_valid); end
        n_cmp++; if (up_bus !== 24'h0003C0) begin n_err++; $display("FAIL mixed_up_bus_c2: got %h want 0003c0", up_bus); end
        step();
        set_idle();
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL mixed_load_blocks: got %b want 0", wb_valid); end
        n_cmp++; if (up_bus !== 24'h0113C0) begin n_err++; $display("FAIL mixed_up_bus_c3: got %h want 0113c0", up_bus); end
        step();
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL mixed_load_wait_c4: got %b want 0", wb_valid); end
        step();
        data_ok = 1'b1;
        rdata   = 32'hCAFEF00D;
        #1;
        n_cmp++; if ({wb_valid, wb_pri[69:38]} !== {1'b1, 32'hCAFEF00D}) begin n_err++; $display("FAIL mixed_load_retire: got %b %h want 1 cafef00d", wb_valid, wb_pri[69:38]); end
        step();
        set_idle();
        #1;
        n_cmp++; if ({wb_valid, wb_pri} !== {1'b1, 32'h222, 5'd8, 1'b1, 32'h3010}) begin n_err++; $display("FAIL mixed_alu_b: got %b %h", wb_valid, wb_pri); end
        n_cmp++; if (wb_sec !== {32'h333, 5'd9, 1'b1, 32'h3014}) begin n_err++; $display("FAIL mixed_alu_b_sec: got %h", wb_sec); end
        n_cmp++; if (bypass !== {32'h333, 5'd9, 1'b1, 32'h222, 5'd8, 1'b1}) begin n_err++; $display("FAIL mixed_bypass: got %h", bypass); end
        n_cmp++; if (up_bus !== 24'h010000) begin n_err++; $display("FAIL mixed_up_bus_c6: got %h want 010000", up_bus); end
        step();
        #1;
        n_cmp++; if ({wb_valid, bypass} !== 77'd0) begin n_err++; $display("FAIL mixed_empty: got %b %h want 0", wb_valid, bypass); end
        step();
    endtask

    task automatic test_sc();
        mem1_valid = 1'b1;
        pri_bus = mk_pri(32'd0, 32'h500, OP_SC, SEL_STORE, 32'd0, 5'd10, 1'b1, 32'h4000);
        step();
        set_idle();
        #1;
        n_cmp++; if ({wb_valid, wb_pri[69:38]} !== {1'b1, 32'd0}) begin n_err++; $display("FAIL sc_fail_retire: got %b %h want 1 0", wb_valid, wb_pri[69:38]); end
        step();
        mem1_valid = 1'b1;
        pri_bus = mk_pri(32'd0, 32'h500, OP_SC, SEL_STORE, 32'd1, 5'd10, 1'b1, 32'h4008);
        step();
        set_idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL sc_wait_%0d: got %b want 0", i, wb_valid); end
            step();
        end
        data_ok = 1'b1;
        rdata   = 32'h1234_5678;
        #1;
        n_cmp++; if ({wb_valid, wb_pri[69:38]} !== {1'b1, 32'd1}) begin n_err++; $display("FAIL sc_ok_retire: got %b %h want 1 1", wb_valid, wb_pri[69:38]); end
        step();
        set_idle();
    endtask

    task automatic test_resp_err();
        do_reset();
        data_ok = 1'b1;
        #1;
        n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL err_before_edge: got %b want 0", resp_err); end
        step();
        set_idle();
        step();
        step();
        #1;
        n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", resp_err); end
        step();
        mem1_valid = 1'b1;
        pri_bus = mk_pri(32'd0, 32'h700, OP_LW, SEL_LOAD, 32'd0, 5'd11, 1'b1, 32'h5000);
        step();
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if ({resp_err, wb_valid, allowin, up_bus} !== {3'b001, 24'd0}) begin n_err++; $display("FAIL err_mid_reset: got err %b valid %b allowin %b up %h", resp_err, wb_valid, allowin, up_bus); end
        data_ok = 1'b1;
        rdata   = 32'h5555_5555;
        step();
        set_idle();
        #1;
        n_cmp++; if ({resp_err, wb_valid} !== 2'b10) begin n_err++; $display("FAIL err_after_reset: got err %b valid %b want 1 0", resp_err, wb_valid); end
        step();
    endtask

    task automatic test_unaligned();
        logic [31:0] exp_lwr, exp_lwl;
`ifdef MEM2_UNALIGNED_EN
        exp_lwr = 32'hAA11_2233;
        exp_lwl = 32'h2233_44DD;
`else
        exp_lwr = 32'hAABB_CCDD;
        exp_lwl = 32'hAABB_CCDD;
`endif
        do_reset();
        mem1_valid = 1'b1;
        pri_bus = mk_pri(32'hAABB_CCDD, 32'h601, OP_LWR, SEL_LOAD, 32'd0, 5'd12, 1'b1, 32'h6000);
        step();
        set_idle();
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL lwr_waits: got %b want 0", wb_valid); end
        step();
        data_ok = 1'b1;
        rdata   = 32'h1122_3344;
        #1;
        n_cmp++; if ({wb_valid, wb_pri[69:38]} !== {1'b1, exp_lwr}) begin n_err++; $display("FAIL lwr_result: got %b %h want 1 %h", wb_valid, wb_pri[69:38], exp_lwr); end
        step();
        mem1_valid = 1'b1;
        data_ok    = 1'b0;
        pri_bus = mk_pri(32'hAABB_CCDD, 32'h602, OP_LWL, SEL_LOAD, 32'd0, 5'd13, 1'b1, 32'h6008);
        step();
        set_idle();
        data_ok = 1'b1;
        rdata   = 32'h1122_3344;
        #1;
        n_cmp++; if ({wb_valid, wb_pri[69:38]} !== {1'b1, exp_lwl}) begin n_err++; $display("FAIL lwl_result: got %b %h want 1 %h", wb_valid, wb_pri[69:38], exp_lwl); end
        step();
        set_idle();
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_res [4];
        exp_res = '{32'h11, 32'h12, 32'h13, 32'h99};
        do_reset();
        wb_allowin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem1_valid = 1'b1;
            pri_bus = mk_pri(32'd0, 32'd0, OP_ADD, SEL_ALU, 32'h10 + 32'(i), 5'(i+1), 1'b1, 32'h7000 + 32'(4*i));
            step();
        end
        mem1_valid = 1'b0;
        #1;
        n_cmp++; if ({allowin, wb_valid} !== 2'b00) begin n_err++; $display("FAIL full_stalled: got allowin %b valid %b want 0 0", allowin, wb_valid); end
        step();
        wb_allowin = 1'b1;
        mem1_valid = 1'b1;
        pri_bus = mk_pri(32'd0, 32'd0, OP_ADD, SEL_ALU, 32'h99, 5'd20, 1'b1, 32'h7100);
        #1;
        n_cmp++; if ({allowin, wb_valid, wb_pri[69:38]} !== {2'b11, 32'h10}) begin n_err++; $display("FAIL full_push_pop: got allowin %b valid %b result %h want 1 1 10", allowin, wb_valid, wb_pri[69:38]); end
        step();
        set_idle();
        for (int j = 0; j < 4; j++) begin
            #1;
            n_cmp++; if ({wb_valid, wb_pri[69:38]} !== {1'b1, exp_res[j]}) begin n_err++; $display("FAIL full_drain_%0d: got %b %h want 1 %h", j, wb_valid, wb_pri[69:38], exp_res[j]); end
            step();
        end
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL full_empty: got %b want 0", wb_valid); end
        step();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sub_word();
        test_wb_stall();
        test_mixed();
        test_sc();
        test_resp_err();
        test_unaligned();
        test_full_pop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
